// File: rtl/game_pkg.sv
// Shared types for the 3x3 turn controller: cell/player codes, FSM states, win-line table.
package game_pkg;

  typedef logic [1:0] pos_t;

  localparam pos_t EMPTY = 2'b00;
  localparam pos_t P1    = 2'b01;
  localparam pos_t P2    = 2'b10;

  typedef enum logic [2:0] {
    TURN_P1,
    TURN_P2,
    CHECK,
    WIN,
    DRAW
  } state_t;

  // Cell numbers 1..9, row-major; index order is the win_line priority.
  localparam int LINE_TBL [8][3] = '{
    '{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9},
    '{1, 4, 7}, '{2, 5, 8}, '{3, 6, 9},
    '{1, 5, 9}, '{3, 5, 7}
  };

  function automatic pos_t other(input pos_t p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/game_ctrl_board_eval.sv
// Combinational board evaluator: lowest-index full line owned by player, and board-full flag.
module board_eval
  import game_pkg::*;
(
  input  logic [17:0] board,
  input  pos_t        player,
  output logic        line_hit,
  output logic [3:0]  line_idx,
  output logic        full
);

  always_comb begin
    line_hit = 1'b0;
    line_idx = '0;
    full     = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (board[2*i +: 2] == EMPTY) full = 1'b0;
    end
    for (int l = 0; l < 8; l++) begin
      if (!line_hit &&
          board[2*(LINE_TBL[l][0]-1) +: 2] == player &&
          board[2*(LINE_TBL[l][1]-1) +: 2] == player &&
          board[2*(LINE_TBL[l][2]-1) +: 2] == player) begin
        line_hit = 1'b1;
        line_idx = 4'(l + 1);
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Turn controller for 3x3 three-in-a-row: ack/err 1 cycle after accept, result 2 cycles after.
// move_ready is low outside TURN states and whenever new_game is asserted.
module game_ctrl
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  input  logic               move_valid,
  input  logic [3:0]         move_pos,
  output logic               move_ready,
  output logic               move_ack,
  output logic               move_err,
  output logic               timeout,
  output logic [17:0]        board,
  output logic [1:0]         turn,
  output logic               game_over,
  output logic [1:0]         who_win,
  output logic [3:0]         win_line,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2
);

  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  state_t             state_q, state_d;
  logic [17:0]        board_q, board_d;
  pos_t               starter_q, starter_d;
  pos_t               mover_q, mover_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               move_ack_q, move_ack_d;
  logic               move_err_q, move_err_d;
  logic               timeout_q, timeout_d;
  pos_t               who_win_q, who_win_d;
  logic [3:0]         win_line_q, win_line_d;
  logic [SCORE_W-1:0] score_p1_q, score_p1_d;
  logic [SCORE_W-1:0] score_p2_q, score_p2_d;
  pos_t               turn_q, turn_d;
  logic               game_over_q, game_over_d;

  logic       in_turn, accept, legal, expire;
  pos_t       cur, cell_sel;
  logic       line_hit, full;
  logic [3:0] line_idx;

  function automatic state_t turn_of(input pos_t p);
    return (p == P2) ? TURN_P2 : TURN_P1;
  endfunction

  board_eval u_eval (
    .board    (board_q),
    .player   (mover_q),
    .line_hit (line_hit),
    .line_idx (line_idx),
    .full     (full)
  );

  always_comb begin
    in_turn    = (state_q == TURN_P1) || (state_q == TURN_P2);
    cur        = (state_q == TURN_P2) ? P2 : P1;
    move_ready = in_turn && !new_game;
    accept     = move_valid && move_ready;
    // Positions outside 1..9 read as occupied so they fall into the reject path.
    cell_sel   = P1;
    for (int i = 0; i < 9; i++) begin
      if (move_pos == 4'(i + 1)) cell_sel = board_q[2*i +: 2];
    end
    legal  = accept && (cell_sel == EMPTY);
    expire = in_turn && (TIMEOUT_CYC != 0) && (timer_q == T_LAST);
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    starter_d  = starter_q;
    mover_d    = mover_q;
    timer_d    = timer_q;
    move_ack_d = 1'b0;
    move_err_d = 1'b0;
    timeout_d  = 1'b0;
    who_win_d  = who_win_q;
    win_line_d = win_line_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;

    if (new_game) begin
      board_d    = '0;
      who_win_d  = EMPTY;
      win_line_d = '0;
      timer_d    = '0;
      if (state_q == WIN || state_q == DRAW) begin
        starter_d = other(starter_q);
        state_d   = turn_of(other(starter_q));
      end else begin
        state_d = turn_of(starter_q);
      end
    end else begin
      case (state_q)
        TURN_P1, TURN_P2: begin
          if (legal) begin
            for (int i = 0; i < 9; i++) begin
              if (move_pos == 4'(i + 1)) board_d[2*i +: 2] = cur;
            end
            move_ack_d = 1'b1;
            mover_d    = cur;
            timer_d    = '0;
            state_d    = CHECK;
          end else begin
            move_err_d = accept;
            if (expire) begin
              timeout_d = 1'b1;
              timer_d   = '0;
              state_d   = turn_of(other(cur));
            end else if (TIMEOUT_CYC != 0) begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        CHECK: begin
          if (line_hit) begin
            state_d    = WIN;
            who_win_d  = mover_q;
            win_line_d = line_idx;
            if (mover_q == P1 && score_p1_q != '1) score_p1_d = score_p1_q + 1'b1;
            if (mover_q == P2 && score_p2_q != '1) score_p2_d = score_p2_q + 1'b1;
          end else if (full) begin
            state_d = DRAW;
          end else begin
            state_d = turn_of(other(mover_q));
            timer_d = '0;
          end
        end
        default: ;
      endcase
    end

    turn_d      = (state_d == TURN_P1) ? P1 : (state_d == TURN_P2) ? P2 : EMPTY;
    game_over_d = (state_d == WIN) || (state_d == DRAW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TURN_P1;
      board_q     <= '0;
      starter_q   <= P1;
      mover_q     <= EMPTY;
      timer_q     <= '0;
      move_ack_q  <= 1'b0;
      move_err_q  <= 1'b0;
      timeout_q   <= 1'b0;
      who_win_q   <= EMPTY;
      win_line_q  <= '0;
      score_p1_q  <= '0;
      score_p2_q  <= '0;
      turn_q      <= P1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      starter_q   <= starter_d;
      mover_q     <= mover_d;
      timer_q     <= timer_d;
      move_ack_q  <= move_ack_d;
      move_err_q  <= move_err_d;
      timeout_q   <= timeout_d;
      who_win_q   <= who_win_d;
      win_line_q  <= win_line_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      turn_q      <= turn_d;
      game_over_q <= game_over_d;
    end
  end

  assign move_ack  = move_ack_q;
  assign move_err  = move_err_q;
  assign timeout   = timeout_q;
  assign board     = board_q;
  assign turn      = turn_q;
  assign game_over = game_over_q;
  assign who_win   = who_win_q;
  assign win_line  = win_line_q;
  assign score_p1  = score_p1_q;
  assign score_p2  = score_p2_q;

endmodule
